xadc_frame_assembler: RTL and testbench

Collects single-channel XADC sequencer samples (AXI-stream with `tid` channel tag) into one frame containing the latest sample of each of `N_CH` configured channels, then presents the frame on an AXI-stream master with optional decimation. It sits between the XADC sequencer stream and the parameter estimator, and replaces ad-hoc alternating V/I feeding with a parametrised, backpressure-aware front end that supports any channel count.

---
 rtl/xadc_pkg.sv | 20 ++
 rtl/xadc_ch_match.sv | 28 ++
 rtl/xadc_frame_assembler.sv | 125 ++++++++++++
 tb/tb_xadc_frame_assembler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared defaults for the XADC frame assembler: widths, sequencer channel tags
// and the collector state encoding.
package xadc_pkg;

    localparam int XADC_DATA_W = 16;
    localparam int XADC_ID_W   = 5;
    localparam int XADC_N_CH   = 2;

    localparam logic [XADC_ID_W-1:0] XADC_ID_VP = 5'h10;  // VP/VN voltage channel
    localparam logic [XADC_ID_W-1:0] XADC_ID_IP = 5'h18;  // current sense channel

    // Slot 0 sits in the low bits, so the voltage tag comes last in the concatenation.
    localparam logic [XADC_N_CH*XADC_ID_W-1:0] XADC_CH_IDS = {XADC_ID_IP, XADC_ID_VP};

    typedef enum logic {
        IDLE,
        COLLECT
    } col_state_t;

endpackage

// File: rtl/xadc_ch_match.sv
// Maps an incoming channel tag onto a one-hot frame slot; the lowest slot wins
// when the tag list contains duplicates.
module xadc_ch_match
    import xadc_pkg::*;
#(
    parameter int                    N_CH   = XADC_N_CH,
    parameter int                    ID_W   = XADC_ID_W,
    parameter logic [N_CH*ID_W-1:0]  CH_IDS = XADC_CH_IDS
) (
    input  logic [ID_W-1:0] tid,
    output logic [N_CH-1:0] slot_oh,
    output logic            hit
);

    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise a tag that
        // matches nothing would leave them unassigned and infer latches.
        slot_oh = '0;
        hit     = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!hit && tid == CH_IDS[k*ID_W +: ID_W]) begin
                slot_oh[k] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xadc_frame_assembler.sv
// Gathers the latest sample of each configured XADC channel into one frame and
// forwards every DECIM-th complete frame on a single-register AXI-stream output.
module xadc_frame_assembler
    import xadc_pkg::*;
#(
    parameter int                    DATA_W = XADC_DATA_W,
    parameter int                    ID_W   = XADC_ID_W,
    parameter int                    N_CH   = XADC_N_CH,
    parameter logic [N_CH*ID_W-1:0]  CH_IDS = XADC_CH_IDS,
    parameter int                    DECIM  = 1
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [DATA_W-1:0]        s_tdata,
    input  logic [ID_W-1:0]          s_tid,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [N_CH*DATA_W-1:0]   m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    input  logic                     flush,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              overrun_cnt,
    output logic [7:0]               bad_id_cnt
);

    localparam logic [15:0] DECIM_LAST = 16'(DECIM - 1);

    col_state_t            state_q, state_d;
    logic                  ready_q;
    logic [N_CH-1:0]       mask_q, mask_d, mask_cur, slot_oh;
    logic [DATA_W-1:0]     cap_q [N_CH];
    logic [N_CH*DATA_W-1:0] frame_cur;
    logic [15:0]           decim_q, decim_d;
    logic                  hit, beat, take, bad_beat, complete;
    logic                  last_phase, out_free, load, drop, valid_d;

    xadc_ch_match #(
        .N_CH   (N_CH),
        .ID_W   (ID_W),
        .CH_IDS (CH_IDS)
    ) u_match (
        .tid     (s_tid),
        .slot_oh (slot_oh),
        .hit     (hit)
    );

    assign s_tready = ready_q;
    assign beat     = s_tvalid & ready_q;

    always_comb begin
        take       = beat & hit & ~flush;
        bad_beat   = beat & ~hit & ~flush;
        mask_cur   = (state_q == IDLE ? '0 : mask_q) | (take ? slot_oh : '0);
        complete   = take & (&mask_cur);
        last_phase = (decim_q == DECIM_LAST);
        out_free   = ~m_tvalid | m_tready;
        load       = complete & last_phase & out_free;
        drop       = complete & last_phase & ~out_free;

        // Frame as it stands after this cycle's beat, so the completing sample is included.
        frame_cur = '0;
        for (int k = 0; k < N_CH; k++) begin
            frame_cur[k*DATA_W +: DATA_W] = (take && slot_oh[k]) ? s_tdata : cap_q[k];
        end

        mask_d  = (flush || complete) ? '0 : mask_cur;
        decim_d = decim_q;
        if (flush) begin
            decim_d = '0;
        end else if (complete) begin
            decim_d = last_phase ? '0 : decim_q + 16'd1;
        end

        valid_d = load | (m_tvalid & ~m_tready);
        state_d = (mask_d == '0) ? IDLE : COLLECT;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values computed above regardless of statement order.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ready_q     <= 1'b0;
            state_q     <= IDLE;
            mask_q      <= '0;
            decim_q     <= '0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            bad_id_cnt  <= '0;
            // NOTE: the capture bank is cleared on reset so no pre-reset sample can
            // ever resurface in a frame; plain datapath storage would normally skip this.
            for (int k = 0; k < N_CH; k++) begin
                cap_q[k] <= '0;
            end
        end else begin
            ready_q  <= 1'b1;
            state_q  <= state_d;
            mask_q   <= mask_d;
            decim_q  <= decim_d;
            m_tvalid <= valid_d;

            for (int k = 0; k < N_CH; k++) begin
                if (take && slot_oh[k]) begin
                    cap_q[k] <= s_tdata;
                end
            end

            if (load) begin
                m_tdata   <= frame_cur;
                frame_cnt <= frame_cnt + 16'd1;
            end

            if (drop && overrun_cnt != 16'hFFFF) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end

            if (bad_beat && bad_id_cnt != 8'hFF) begin
                bad_id_cnt <= bad_id_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_xadc_frame_assembler.sv
// Scoreboard bench: three assembler instances (defaults, DECIM=4, three channels)
// with expected frames queued by the stimulus and checked by per-instance monitors.
module tb_xadc_frame_assembler;

    logic        clk = 1'b0;
    logic        rst_ab, rst_c;
    logic [15:0] s_tdata;
    logic [4:0]  s_tid;
    logic        vld_a, vld_b, vld_c, flush;
    logic        rdy_a, rdy_b, rdy_c;

    logic        s_tready_a, s_tready_b, s_tready_c;
    logic [31:0] m_tdata_a, m_tdata_b;
    logic [47:0] m_tdata_c;
    logic        m_tvalid_a, m_tvalid_b, m_tvalid_c;
    logic [15:0] frame_a, frame_b, frame_c, over_a, over_b, over_c;
    logic [7:0]  bad_a, bad_b, bad_c;

    logic [63:0] q_a[$], q_b[$], q_c[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    xadc_frame_assembler u_a (
        .ap_clk(clk), .ap_rst_n(rst_ab), .s_tdata(s_tdata), .s_tid(s_tid),
        .s_tvalid(vld_a), .s_tready(s_tready_a), .m_tdata(m_tdata_a),
        .m_tvalid(m_tvalid_a), .m_tready(rdy_a), .flush(flush),
        .frame_cnt(frame_a), .overrun_cnt(over_a), .bad_id_cnt(bad_a)
    );

    xadc_frame_assembler #(.DECIM(4)) u_b (
        .ap_clk(clk), .ap_rst_n(rst_ab), .s_tdata(s_tdata), .s_tid(s_tid),
        .s_tvalid(vld_b), .s_tready(s_tready_b), .m_tdata(m_tdata_b),
        .m_tvalid(m_tvalid_b), .m_tready(rdy_b), .flush(flush),
        .frame_cnt(frame_b), .overrun_cnt(over_b), .bad_id_cnt(bad_b)
    );

    xadc_frame_assembler #(.N_CH(3), .CH_IDS({5'h19, 5'h18, 5'h10})) u_c (
        .ap_clk(clk), .ap_rst_n(rst_c), .s_tdata(s_tdata), .s_tid(s_tid),
        .s_tvalid(vld_c), .s_tready(s_tready_c), .m_tdata(m_tdata_c),
        .m_tvalid(m_tvalid_c), .m_tready(rdy_c), .flush(flush),
        .frame_cnt(frame_c), .overrun_cnt(over_c), .bad_id_cnt(bad_c)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic beat(input int dut, input logic [4:0] id, input logic [15:0] d, input logic fl = 1'b0);
        s_tid   = id;
        s_tdata = d;
        flush   = fl;
        vld_a   = (dut == 0);
        vld_b   = (dut == 1);
        vld_c   = (dut == 2);
        @(posedge clk);
        #1;
        vld_a = 1'b0;
        vld_b = 1'b0;
        vld_c = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spurious(input string name, input logic [63:0] actual);
        checks++;
        errors++;
        $display("FAIL %s: unexpected frame 0x%0h, expected none", name, actual);
    endtask

    // Monitors: a stalled frame must match the queue head; a consumed frame pops it.
    always @(negedge clk) begin
        if (m_tvalid_a) begin
            if (q_a.size() == 0)  spurious("a_frame", 64'(m_tdata_a));
            else if (rdy_a)       check("a_frame", 64'(m_tdata_a), q_a.pop_front());
            else                  check("a_hold", 64'(m_tdata_a), q_a[0]);
        end
    end

    always @(negedge clk) begin
        if (m_tvalid_b) begin
            if (q_b.size() == 0)  spurious("b_frame", 64'(m_tdata_b));
            else if (rdy_b)       check("b_frame", 64'(m_tdata_b), q_b.pop_front());
            else                  check("b_hold", 64'(m_tdata_b), q_b[0]);
        end
    end

    always @(negedge clk) begin
        if (m_tvalid_c) begin
            if (q_c.size() == 0)  spurious("c_frame", 64'(m_tdata_c));
            else if (rdy_c)       check("c_frame", 64'(m_tdata_c), q_c.pop_front());
            else                  check("c_hold", 64'(m_tdata_c), q_c[0]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ab = 1'b0; rst_c = 1'b0;
        s_tdata = '0; s_tid = '0; flush = 1'b0;
        vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        idle(3);

        check("rst_tready", 64'(s_tready_a), 64'd0);
        check("rst_tvalid", 64'(m_tvalid_a), 64'd0);
        check("rst_tdata",  64'(m_tdata_a),  64'd0);
        check("rst_frames", 64'(frame_a),    64'd0);
        check("rst_over",   64'(over_a),     64'd0);
        check("rst_bad",    64'(bad_a),      64'd0);

        rst_ab = 1'b1; rst_c = 1'b1;
        idle(1);
        check("tready_up", 64'(s_tready_a), 64'd1);

        // Basic frame
        q_a.push_back(64'h0456_0123);
        beat(0, 5'h10, 16'h0123);
        beat(0, 5'h18, 16'h0456);
        check("latency_valid", 64'(m_tvalid_a), 64'd1);
        idle(1);
        check("one_cycle_valid", 64'(m_tvalid_a), 64'd0);
        check("frames_1", 64'(frame_a), 64'd1);

        // Repeated slot: latest wins
        q_a.push_back(64'h0003_0002);
        beat(0, 5'h10, 16'd1);
        beat(0, 5'h10, 16'd2);
        beat(0, 5'h18, 16'd3);
        idle(3);
        check("frames_2", 64'(frame_a), 64'd2);

        // Stalled output: first frame held, later two lost
        rdy_a = 1'b0;
        q_a.push_back(64'h00B1_00A1);
        beat(0, 5'h10, 16'h00A1); beat(0, 5'h18, 16'h00B1);
        beat(0, 5'h10, 16'h00A2); beat(0, 5'h18, 16'h00B2);
        beat(0, 5'h10, 16'h00A3); beat(0, 5'h18, 16'h00B3);
        idle(3);
        check("overrun_2", 64'(over_a), 64'd2);
        check("stall_valid", 64'(m_tvalid_a), 64'd1);
        check("frames_3", 64'(frame_a), 64'd3);
        rdy_a = 1'b1;
        idle(1);
        check("drain_valid", 64'(m_tvalid_a), 64'd0);

        // Unknown tag saturates the bad-id counter
        for (int i = 0; i < 300; i++) beat(0, 5'h05, 16'(i));
        idle(2);
        check("bad_sat", 64'(bad_a), 64'hFF);
        check("bad_no_frame", 64'(frame_a), 64'd3);

        // Flush discards the partial frame
        beat(0, 5'h10, 16'd7);
        flush = 1'b1; idle(1); flush = 1'b0;
        beat(0, 5'h18, 16'd8);
        idle(3);
        check("flush_no_frame", 64'(frame_a), 64'd3);
        q_a.push_back(64'h0008_0009);
        beat(0, 5'h10, 16'd9);
        idle(2);
        check("frames_4", 64'(frame_a), 64'd4);

        // A beat coinciding with flush is dropped as well
        beat(0, 5'h10, 16'h0011);
        beat(0, 5'h18, 16'h0022, 1'b1);
        beat(0, 5'h18, 16'h0033);
        idle(2);
        check("flush_beat_no_frame", 64'(frame_a), 64'd4);
        q_a.push_back(64'h0033_0044);
        beat(0, 5'h10, 16'h0044);
        idle(2);
        check("frames_5", 64'(frame_a), 64'd5);
        check("a_queue_empty", 64'(q_a.size()), 64'd0);

        // Decimation by 4, back-to-back beats
        for (int i = 1; i <= 8; i++) begin
            if (i % 4 == 0) q_b.push_back({32'd0, 16'(16'h0100 + i), 16'(i)});
            beat(1, 5'h10, 16'(i));
            beat(1, 5'h18, 16'(16'h0100 + i));
        end
        idle(3);
        check("decim_frames", 64'(frame_b), 64'd2);
        check("decim_over", 64'(over_b), 64'd0);
        check("b_queue_empty", 64'(q_b.size()), 64'd0);

        // Three channels, reset mid-frame
        beat(2, 5'h10, 16'd1);
        beat(2, 5'h18, 16'd2);
        rst_c = 1'b0;
        idle(2);
        check("c_rst_tready", 64'(s_tready_c), 64'd0);
        check("c_rst_tvalid", 64'(m_tvalid_c), 64'd0);
        check("c_rst_tdata",  64'(m_tdata_c),  64'd0);
        rst_c = 1'b1;
        idle(1);
        beat(2, 5'h19, 16'h0333);
        idle(2);
        check("c_no_partial", 64'(frame_c), 64'd0);
        q_c.push_back(64'h0333_0222_0111);
        beat(2, 5'h10, 16'h0111);
        beat(2, 5'h18, 16'h0222);
        idle(2);
        check("c_frames", 64'(frame_c), 64'd1);
        check("c_queue_empty", 64'(q_c.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
